// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch stage with misaligned-target trap.
// Optional build macro BRANCH_STATS_EN adds the retired_cnt/taken_cnt statistics outputs.
// Ports:
//   clk, rst                  core clock, async active-high reset
//   next_pc_src, target       branch decision and ALU target, used on retire
//   retire                    current instruction consumed (EXEC only)
//   imem_req/addr/ready/rdata instruction memory handshake
//   inst, inst_valid          fetched instruction presented to decode
//   pc, pc_plus4              current pc and its sequential successor
//   misalign_trap, trap_clear trap flag and its acknowledge (TRAP only)
//   retired_cnt, taken_cnt    retire/taken statistics (BRANCH_STATS_EN only)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
`ifdef BRANCH_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_pc_src,
  input  logic [31:0] target,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_trap,
`ifdef BRANCH_STATS_EN
  output logic [STAT_W-1:0] retired_cnt,
  output logic [STAT_W-1:0] taken_cnt,
`endif
  input  logic        trap_clear
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} state_t;
  state_t state;
  logic [31:0] nxt;
  assign imem_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  // bit 0 of a jump target is always dropped; only bit 1 can misalign
  assign nxt = next_pc_src ? (target & ~32'd1) : pc_plus4;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      inst <= '0;
      imem_req <= 1'b0;
      inst_valid <= 1'b0;
      misalign_trap <= 1'b0;
`ifdef BRANCH_STATS_EN
      retired_cnt <= '0;
      taken_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: if (imem_ready) begin
          inst <= imem_rdata;
          state <= EXEC;
          imem_req <= 1'b0;
          inst_valid <= 1'b1;
        end
        EXEC: if (retire) begin
          inst_valid <= 1'b0;
`ifdef BRANCH_STATS_EN
          retired_cnt <= retired_cnt + STAT_W'(1);
          taken_cnt <= taken_cnt + STAT_W'(next_pc_src);
`endif
          if (nxt[1]) begin
            state <= TRAP;
            misalign_trap <= 1'b1;
          end else begin
            pc <= nxt;
            state <= FETCH;
            imem_req <= 1'b1;
          end
        end
        TRAP: if (trap_clear) begin
          pc <= TRAP_PC;
          misalign_trap <= 1'b0;
          state <= FETCH;
          imem_req <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit fetch, retire, trap, wrap and async reset.
module tb_pc_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic next_pc_src = 1'b0, retire = 1'b0, imem_ready = 1'b0, trap_clear = 1'b0;
  logic [31:0] target = '0, imem_rdata = '0;
  logic imem_req, inst_valid, misalign_trap;
  logic [31:0] imem_addr, inst, pc, pc_plus4;
`ifdef BRANCH_STATS_EN
  logic [31:0] retired_cnt, taken_cnt;
`endif
  int n_checks = 0, n_err = 0;
  int m_ret = 0, m_taken = 0;
  logic [31:0] mpc;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_inst[$];

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .next_pc_src(next_pc_src), .target(target), .retire(retire),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
    .misalign_trap(misalign_trap),
`ifdef BRANCH_STATS_EN
    .retired_cnt(retired_cnt), .taken_cnt(taken_cnt),
`endif
    .trap_clear(trap_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int stall);
    logic [31:0] a, w;
    for (int i = 0; i < 8 && !imem_req; i++) tick();
    chk("req_seen", imem_req, 1);
    chk("addr_q_nonempty", exp_addr.size() != 0, 1);
    a = exp_addr.size() != 0 ? exp_addr.pop_front() : 32'hDEAD_BEEF;
    imem_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, a);
      chk("stall_valid", inst_valid, 0);
      tick();
    end
    chk("fetch_addr", imem_addr, a);
    chk("fetch_plus4", pc_plus4, a + 32'd4);
    w = {a[23:0], 8'h13};
    imem_ready = 1'b1;
    imem_rdata = w;
    exp_inst.push_back(w);
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk("exec_valid", inst_valid, 1);
    chk("exec_req", imem_req, 0);
    chk("inst_q_nonempty", exp_inst.size() != 0, 1);
    chk("exec_inst", inst, exp_inst.size() != 0 ? exp_inst.pop_front() : 32'hDEAD_BEEF);
  endtask

  task automatic do_retire(input logic src, input logic [31:0] tgt);
    logic [31:0] n;
    n = src ? {tgt[31:1], 1'b0} : mpc + 32'd4;
    m_ret++;
    if (src) m_taken++;
    retire = 1'b1;
    next_pc_src = src;
    target = tgt;
    tick();
    retire = 1'b0;
    next_pc_src = 1'b0;
    target = $urandom;
    chk("ret_valid", inst_valid, 0);
    if (n[1]) begin
      chk("trap_flag", misalign_trap, 1);
      chk("trap_pc", pc, mpc);
      chk("trap_req", imem_req, 0);
    end else begin
      mpc = n;
      exp_addr.push_back(n);
      chk("ret_pc", pc, n);
      chk("ret_req", imem_req, 1);
      chk("ret_trap", misalign_trap, 0);
    end
  endtask

  initial begin
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_trap", misalign_trap, 0);
    tick();
    rst = 1'b0;
    mpc = 32'h0;
    exp_addr.push_back(32'h0);
    chk("idle_req", imem_req, 0);
    tick();
    chk("first_req", imem_req, 1);
    do_fetch(0);
    do_retire(1'b0, 32'h0000_0041);
    do_fetch(0);
    do_retire(1'b0, 32'h0);
    do_fetch(0);
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_0000;
    next_pc_src = 1'b1;
    target = 32'h0000_0022;
    tick();
    imem_ready = 1'b0;
    chk("hold_valid", inst_valid, 1);
    chk("hold_pc", pc, 32'h8);
    chk("hold_inst", inst, 32'h0000_0813);
    do_retire(1'b1, 32'h0000_0041);
    do_fetch(0);
    do_retire(1'b1, 32'h0000_0022);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("trap_hold", misalign_trap, 1);
    chk("trap_hold_pc", pc, 32'h40);
    chk("trap_hold_valid", inst_valid, 0);
    trap_clear = 1'b1;
    tick();
    trap_clear = 1'b0;
    mpc = 32'h100;
    exp_addr.push_back(32'h100);
    chk("clr_trap", misalign_trap, 0);
    chk("clr_pc", pc, 32'h100);
    chk("clr_req", imem_req, 1);
    do_fetch(0);
    do_retire(1'b1, 32'h0000_0010);
    do_fetch(3);
    do_retire(1'b1, 32'hFFFF_FFFC);
    do_fetch(1);
    do_retire(1'b0, 32'h0000_0002);
    do_fetch(0);
    do_retire(1'b0, 32'h0);
`ifdef BRANCH_STATS_EN
    chk("retired_cnt", retired_cnt, m_ret);
    chk("taken_cnt", taken_cnt, m_taken);
`endif
    chk("mid_req", imem_req, 1);
    chk("mid_pc", pc, 32'h4);
    rst = 1'b1;
    #2;
    chk("async_req", imem_req, 0);
    chk("async_pc", pc, 32'h0);
    chk("async_valid", inst_valid, 0);
`ifdef BRANCH_STATS_EN
    chk("rst_retired_cnt", retired_cnt, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
`endif
    tick();
    rst = 1'b0;
    tick();
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
